vend_change_dispenser: RTL
==========================

VEND_CHANGE_DISPENSER -- requirements
Module: vend_change_dispenser

Interface
REQ-001 SHALL have parameter TUBE_DEPTH, default 15: coin capacity per tube, max 15.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15: max cycles to wait for hopper_ack per coin, 1..15.
REQ-003 clock  in  1  the single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  change request present.
REQ-006 req_amount  in  3  change owed in units of 10 (0..7 = 0..70).
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 coin_out  out  2  coin being dispensed: 2'b01 = 10, 2'b10 = 20, 2'b00 = none.
REQ-009 hopper_strobe  out  1  dispense command to the hopper.
REQ-010 hopper_ack  in  1  hopper has released the coin.
REQ-011 refill_valid  in  1  one coin inserted into a tube this cycle.
REQ-012 refill_is20  in  1  refill coin type: 1 = 20, 0 = 10.
REQ-013 busy  out  1  a request is in progress.
REQ-014 done  out  1  one-cycle pulse at the end of a request.
REQ-015 short  out  1  qualifies done: full amount not paid.
REQ-016 paid  out  3  amount actually paid, in units of 10; valid with done, held until next accept.
REQ-017 timeout_err  out  1  sticky hopper-timeout flag.
REQ-018 tube10_count, tube20_count  out  4 each  current tube fill levels.

Function
REQ-019 FSM states SHALL be IDLE, SELECT, ISSUE, GAP, FINISH.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready, latching req_amount into remaining and clearing paid, short and timeout_err.
REQ-021 IDLE -> SELECT on accept; busy SHALL be 1 in every state except IDLE.
REQ-022 SELECT (one cycle) SHALL choose greedily: 20 if remaining >= 2 and tube20_count > 0; else 10 if remaining >= 1 and tube10_count > 0; else go to FINISH.
REQ-023 ISSUE SHALL drive hopper_strobe = 1 with coin_out stable at the chosen type until hopper_ack is sampled 1; coin_out SHALL be 2'b00 whenever hopper_strobe = 0.
REQ-024 On ack in ISSUE: remaining decreases by coin value, paid increases by coin value, the chosen tube decrements, next state GAP.
REQ-025 GAP SHALL hold hopper_strobe low for exactly one cycle, then return to SELECT.
REQ-026 The first hopper_strobe SHALL rise two cycles after the accept edge.
REQ-027 If hopper_ack is not seen within ACK_TIMEOUT cycles of ISSUE, the block SHALL set timeout_err, drop the strobe and go to FINISH without changing counts.
REQ-028 FINISH (one cycle) SHALL pulse done, set short = 1 if remaining != 0, then return to IDLE.
REQ-029 req_amount = 0 SHALL give done in the cycle after SELECT with paid = 0, short = 0 and no strobe.
REQ-030 hopper_ack outside ISSUE SHALL be ignored.
REQ-031 Refill SHALL be accepted in any state and increment the selected tube, saturating at TUBE_DEPTH.
REQ-032 A refill and a dispense of the same tube in one cycle SHALL leave that count unchanged.

Reset
REQ-033 On reset: state IDLE, req_ready 1, hopper_strobe 0, coin_out 2'b00, busy 0, done 0, short 0, paid 0, timeout_err 0, tube10_count 0, tube20_count 0.
REQ-034 Reset during ISSUE SHALL drop hopper_strobe in the next cycle and discard the request with no done pulse.

Configuration
REQ-035 Macro VEND_CHANGE_INVENTORY_EN defined: tube counting, refill and the tube-empty rules of REQ-022 apply as written.
REQ-036 Macro undefined: tubes are treated as never empty, both count outputs read TUBE_DEPTH constantly, refill inputs are ignored, and short is set only after a timeout.

Verification
REQ-037 Inventory on, tubes 5/5, request 7 -> coins 20,20,20,10; paid = 7, short = 0, tube20 = 2, tube10 = 4.
REQ-038 Tubes 10 = 3, 20 = 0, request 5 -> five strobes would be needed but only three 10 coins exist: coins 10,10,10; done with paid = 3, short = 1.
REQ-039 Request 2 with hopper_ack held low -> strobe held for exactly 15 cycles, then timeout_err = 1, done with paid = 0, short = 1.
REQ-040 Request 0 -> done two cycles after accept, paid = 0, short = 0, no strobe.
REQ-041 tube20 = 15 plus refill_is20 pulse -> stays 15; refill_is20 in the cycle of a 20 ack -> count unchanged.
REQ-042 Assert reset mid-ISSUE -> next cycle strobe 0, busy 0, counts 0, no done pulse.

Source files
------------

// File: rtl/vend_change_dispenser.sv
// Change dispenser: pays a requested amount in 20/10 coins through a strobe/ack hopper handshake.
// Define VEND_CHANGE_INVENTORY_EN to enable tube counting, refill and tube-empty selection.
module vend_change_dispenser #(
  parameter int TUBE_DEPTH  = 15,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_amount,
  output logic       req_ready,
  output logic [1:0] coin_out,
  output logic       hopper_strobe,
  input  logic       hopper_ack,
  input  logic       refill_valid,
  input  logic       refill_is20,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic [2:0] paid,
  output logic       timeout_err,
  output logic [3:0] tube10_count,
  output logic [3:0] tube20_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SELECT = 3'd1;
  localparam logic [2:0] ISSUE  = 3'd2;
  localparam logic [2:0] GAP    = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN10    = 2'b01;
  localparam logic [1:0] COIN20    = 2'b10;

  localparam logic [3:0] DEPTH    = 4'(TUBE_DEPTH);
  localparam logic [3:0] TMO_LAST = 4'(ACK_TIMEOUT - 1);

  logic [2:0] state_reg;
  logic [2:0] remaining_reg;
  logic [2:0] paid_reg;
  logic       short_reg;
  logic       timeout_reg;
  logic [1:0] coin_reg;
  logic [3:0] wait_reg;
  logic [2:0] coin_val;
  logic       ack_take;
  logic       have10;
  logic       have20;

  assign coin_val = (coin_reg == COIN20) ? 3'd2 : 3'd1;
  assign ack_take = (state_reg == ISSUE) && hopper_ack;

`ifdef VEND_CHANGE_INVENTORY_EN
  logic [3:0] tube10_reg;
  logic [3:0] tube20_reg;
  logic       take10;
  logic       take20;
  logic       add10;
  logic       add20;

  assign take10 = ack_take && (coin_reg == COIN10);
  assign take20 = ack_take && (coin_reg == COIN20);
  assign add10  = refill_valid && !refill_is20;
  assign add20  = refill_valid && refill_is20;

  // A refill landing on the same tube as a dispense cancels out.
  always_ff @(posedge clock) begin
    if (reset) begin
      tube10_reg <= 4'd0;
      tube20_reg <= 4'd0;
    end else begin
      if (add10 && !take10) begin
        if (tube10_reg < DEPTH) tube10_reg <= tube10_reg + 4'd1;
      end else if (take10 && !add10) begin
        tube10_reg <= tube10_reg - 4'd1;
      end
      if (add20 && !take20) begin
        if (tube20_reg < DEPTH) tube20_reg <= tube20_reg + 4'd1;
      end else if (take20 && !add20) begin
        tube20_reg <= tube20_reg - 4'd1;
      end
    end
  end

  assign have10       = (tube10_reg != 4'd0);
  assign have20       = (tube20_reg != 4'd0);
  assign tube10_count = tube10_reg;
  assign tube20_count = tube20_reg;
`else
  logic unused_refill;

  assign unused_refill = refill_valid ^ refill_is20;
  assign have10        = 1'b1;
  assign have20        = 1'b1;
  assign tube10_count  = DEPTH;
  assign tube20_count  = DEPTH;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= 3'd0;
      paid_reg      <= 3'd0;
      short_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
      coin_reg      <= COIN_NONE;
      wait_reg      <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            remaining_reg <= req_amount;
            paid_reg      <= 3'd0;
            short_reg     <= 1'b0;
            timeout_reg   <= 1'b0;
            state_reg     <= SELECT;
          end
        end
        SELECT: begin
          wait_reg <= 4'd0;
          if ((remaining_reg >= 3'd2) && have20) begin
            coin_reg  <= COIN20;
            state_reg <= ISSUE;
          end else if ((remaining_reg != 3'd0) && have10) begin
            coin_reg  <= COIN10;
            state_reg <= ISSUE;
          end else begin
            short_reg <= (remaining_reg != 3'd0);
            state_reg <= FINISH;
          end
        end
        ISSUE: begin
          // An ack on the last allowed cycle still wins over the timeout.
          if (hopper_ack) begin
            remaining_reg <= remaining_reg - coin_val;
            paid_reg      <= paid_reg + coin_val;
            state_reg     <= GAP;
          end else if (wait_reg == TMO_LAST) begin
            timeout_reg <= 1'b1;
            short_reg   <= (remaining_reg != 3'd0);
            state_reg   <= FINISH;
          end else begin
            wait_reg <= wait_reg + 4'd1;
          end
        end
        GAP:     state_reg <= SELECT;
        FINISH:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_reg == IDLE);
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == FINISH);
  assign hopper_strobe = (state_reg == ISSUE);
  assign coin_out      = hopper_strobe ? coin_reg : COIN_NONE;
  assign short         = short_reg;
  assign paid          = paid_reg;
  assign timeout_err   = timeout_reg;

endmodule
